// File: rtl/burst_window_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : burst_window_ram                                             |
// | Description : Single-clock word RAM with a burst window-read engine.       |
// |               A request fetches NWORDS consecutive words from a base       |
// |               address, LANES words per cycle, into a registered snapshot   |
// |               that is held until the consumer acknowledges it.             |
// | Options     : BWRAM_WRITE_BYPASS_EN - defined: same-cycle write/fetch      |
// |               collision returns the written data (write-first);            |
// |               undefined: the pre-write word is captured (read-first).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module burst_window_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int NWORDS = 9,
  parameter int LANES  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_req,
  input  logic [ADDR_W-1:0]        rd_base,
  input  logic                     rd_ack,
  output logic                     rd_busy,
  output logic                     rd_valid,
  output logic [NWORDS*DATA_W-1:0] rd_data
);

  localparam int c_DEPTH  = 1 << ADDR_W;
  localparam int c_BEATS  = NWORDS / LANES;
  localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     w_accept;
  logic                     w_fetch;
  logic [ADDR_W-1:0]        r_base;
  logic [c_BEAT_W-1:0]      r_beat;
  logic [DATA_W-1:0]        r_mem [c_DEPTH];
  logic [ADDR_W-1:0]        w_lane_addr [LANES];
  logic [LANES*DATA_W-1:0]  w_lane_flat;
  logic [NWORDS*DATA_W-1:0] r_data;

  // The window must split into whole beats; refuse to elaborate otherwise.
  generate
    if (((NWORDS % LANES) != 0) || (NWORDS < LANES)) begin : g_bad_params
      $error("burst_window_ram: NWORDS must be a non-zero multiple of LANES");
    end
  endgenerate

  // Write port: always accepted, independent of the read engine.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // One read port per lane; addresses wrap naturally in ADDR_W bits.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lane_addr[i] = r_base + ADDR_W'((32'(r_beat) * LANES) + i);
`ifdef BWRAM_WRITE_BYPASS_EN
    // Write-first: a lane hitting the address being written sees the new word.
    assign w_lane_flat[i*DATA_W +: DATA_W] =
        (we && (wr_addr == w_lane_addr[i])) ? wr_data : r_mem[w_lane_addr[i]];
`else
    // Read-first: the array update lands after this edge, so the old word is captured.
    assign w_lane_flat[i*DATA_W +: DATA_W] = r_mem[w_lane_addr[i]];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a request is only accepted from IDLE or together with an ack in HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fetch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch = 1'b1;
        if (r_beat == c_LAST_BEAT) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rd_ack) begin
          if (rd_req) begin
            w_accept    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Base address latch and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_beat <= '0;
    end else if (w_accept) begin
      r_base <= rd_base;
      r_beat <= '0;
    end else if (w_fetch) begin
      r_beat <= (r_beat == c_LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  // Snapshot: each beat fills its own LANES slots; everything else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_fetch) begin
      for (int b = 0; b < c_BEATS; b++) begin
        if (r_beat == c_BEAT_W'(b)) begin
          r_data[b*LANES*DATA_W +: LANES*DATA_W] <= w_lane_flat;
        end
      end
    end
  end

  assign rd_busy  = (r_state != S_IDLE);
  assign rd_valid = (r_state == S_HOLD);
  assign rd_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_burst_window_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_burst_window_ram                                          |
// | Description : Directed self-checking bench for burst_window_ram, default   |
// |               configuration plus a reduced-parameter instance.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_burst_window_ram;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 9;
  localparam int LN = 3;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              rd_req;
  logic [AW-1:0]     rd_base;
  logic              rd_ack;
  logic              rd_busy;
  logic              rd_valid;
  logic [NW*DW-1:0]  rd_data;

  logic              s_we;
  logic [3:0]        s_wr_addr;
  logic [15:0]       s_wr_data;
  logic              s_rd_req;
  logic [3:0]        s_rd_base;
  logic              s_rd_ack;
  logic              s_rd_busy;
  logic              s_rd_valid;
  logic [127:0]      s_rd_data;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [31:0]       exp_win [NW];

  burst_window_ram #(
    .ADDR_W(AW), .DATA_W(DW), .NWORDS(NW), .LANES(LN)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_base (rd_base),
    .rd_ack  (rd_ack),
    .rd_busy (rd_busy),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  burst_window_ram #(
    .ADDR_W(4), .DATA_W(16), .NWORDS(8), .LANES(4)
  ) u_dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (s_we),
    .wr_addr (s_wr_addr),
    .wr_data (s_wr_data),
    .rd_req  (s_rd_req),
    .rd_base (s_rd_base),
    .rd_ack  (s_rd_ack),
    .rd_busy (s_rd_busy),
    .rd_valid(s_rd_valid),
    .rd_data (s_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    tick();
    we = 1'b0;
  endtask

  function automatic logic [31:0] slot(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic check_window(input string tag);
    for (int k = 0; k < NW; k++) begin
      check_val($sformatf("%s_slot%0d", tag, k), slot(k), exp_win[k]);
    end
  endtask

  // Called at the falling edge right after the accepting edge.
  task automatic wait_window(input string tag);
    for (int n = 0; n < 3; n++) begin
      check_val($sformatf("%s_busy_c%0d", tag, n), {31'b0, rd_busy}, 32'd1);
      check_val($sformatf("%s_novalid_c%0d", tag, n), {31'b0, rd_valid}, 32'd0);
      tick();
    end
    check_val({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
  endtask

  task automatic request(input logic [AW-1:0] b);
    rd_req = 1'b1; rd_base = b;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic release_win(input string tag);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check_val({tag, "_idle_busy"}, {31'b0, rd_busy}, 32'd0);
    check_val({tag, "_idle_valid"}, {31'b0, rd_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_base = '0; rd_ack = 1'b0;
    s_we = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rd_req = 1'b0; s_rd_base = '0; s_rd_ack = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_busy", {31'b0, rd_busy}, 32'd0);
    check_val("rst_valid", {31'b0, rd_valid}, 32'd0);
    check_val("rst_data", {31'b0, |rd_data}, 32'd0);
    check_val("rst_s_valid", {31'b0, s_rd_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Preload
    for (int i = 0; i < 16; i++) wr(AW'(i), 32'(i + 100));
    for (int j = 0; j < 9; j++) wr(AW'(20 + j), 32'h200 + 32'(j));

    // Basic window at base 2
    request(8'd2);
    wait_window("t1");
    for (int k = 0; k < NW; k++) exp_win[k] = 32'(102 + k);
    check_window("t1");

    // Hold: requests ignored, fetched-address write leaves snapshot stale
    rd_req = 1'b1; rd_base = 8'd50;
    wr(8'd3, 32'h333);
    for (int n = 0; n < 9; n++) begin
      tick();
      check_val($sformatf("t3_hold_valid_c%0d", n), {31'b0, rd_valid}, 32'd1);
    end
    check_window("t3_hold");
    wr(8'd3, 32'd103);
    // Ack together with a new request: straight back to FETCH
    rd_ack = 1'b1; rd_base = 8'd20;
    tick();
    rd_ack = 1'b0; rd_req = 1'b0;
    wait_window("t3_b2b");
    for (int k = 0; k < NW; k++) exp_win[k] = 32'h200 + 32'(k);
    check_window("t3_b2b");
    release_win("t3");

    // Reset during beat 1
    request(8'd2);
    tick();
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_busy", {31'b0, rd_busy}, 32'd0);
    check_val("t5_rst_valid", {31'b0, rd_valid}, 32'd0);
    check_val("t5_rst_data", {31'b0, |rd_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    request(8'd2);
    wait_window("t5");
    for (int k = 0; k < NW; k++) exp_win[k] = 32'(102 + k);
    check_window("t5");
    release_win("t5");

    // Address wrap at top of memory
    wr(8'd254, 32'hAA);
    wr(8'd255, 32'hBB);
    for (int i = 0; i < 7; i++) wr(AW'(i), 32'(i));
    request(8'd254);
    wait_window("t2");
    exp_win[0] = 32'hAA; exp_win[1] = 32'hBB;
    for (int k = 2; k < NW; k++) exp_win[k] = 32'(k - 2);
    check_window("t2");
    release_win("t2");

    // Same-cycle collision on beat 1 and write to an already-fetched slot on beat 2
    wr(8'd4, 32'h11);
    request(8'd0);
    tick();
    we = 1'b1; wr_addr = 8'd4; wr_data = 32'h22;
    tick();
    wr_addr = 8'd0; wr_data = 32'h33;
    tick();
    we = 1'b0;
    check_val("t4_valid", {31'b0, rd_valid}, 32'd1);
    for (int k = 0; k < 7; k++) exp_win[k] = 32'(k);
    exp_win[7] = 32'd107; exp_win[8] = 32'd108;
`ifdef BWRAM_WRITE_BYPASS_EN
    exp_win[4] = 32'h22;
`else
    exp_win[4] = 32'h11;
`endif
    check_window("t4");
    release_win("t4");
    request(8'd0);
    wait_window("t4_re");
    exp_win[0] = 32'h33; exp_win[4] = 32'h22;
    check_window("t4_re");
    release_win("t4_re");

    // Reduced-parameter instance, wrap from base 14
    for (int i = 0; i < 16; i++) begin
      s_we = 1'b1; s_wr_addr = 4'(i); s_wr_data = 16'h1000 + 16'(i);
      tick();
    end
    s_we = 1'b0;
    s_rd_req = 1'b1; s_rd_base = 4'd14;
    tick();
    s_rd_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      check_val($sformatf("t6_busy_c%0d", n), {31'b0, s_rd_busy}, 32'd1);
      check_val($sformatf("t6_novalid_c%0d", n), {31'b0, s_rd_valid}, 32'd0);
      tick();
    end
    check_val("t6_valid", {31'b0, s_rd_valid}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("t6_slot%0d", k), {16'b0, s_rd_data[k*16 +: 16]},
                32'h1000 + 32'((14 + k) % 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
